// File: rtl/spi_reg_bridge_pkg.sv
// SPI byte-stream to register-bus bridge: shared types.
// States of the command decoder plus command-byte field positions.
package spi_reg_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      WR_REQ,
      RD_REQ,
      RD_SEND
   } state_e;

   localparam int CMD_RD_BIT = 7;
   localparam int ADDR_W     = 7;

endpackage

// File: rtl/axis_spi_reg_bridge.sv
// SPI byte-stream to register-bus bridge.
// Decodes SPI bytes into register writes/reads; returns read data as bytes.
//   s_axis_*   : bytes received by the SPI slave (never stalled)
//   m_axis_*   : read-response bytes to the SPI slave TX
//   reg_*      : level request / one-cycle ack register bus
//   stat_*     : one-cycle pulses for timeout abort and dropped byte
module axis_spi_reg_bridge
   import spi_reg_bridge_pkg::*;
#(
   parameter int DATA_BYTES     = 2,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [7:0]              s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [ADDR_W-1:0]       reg_addr,
   output logic [8*DATA_BYTES-1:0] reg_wdata,
   output logic                    reg_wr,
   output logic                    reg_rd,
   input  logic [8*DATA_BYTES-1:0] reg_rdata,
   input  logic                    reg_ack,
   output logic                    stat_timeout,
   output logic                    stat_drop
);

   localparam int DW = 8 * DATA_BYTES;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int CW = 3;

   localparam logic [CW-1:0] LAST_WB = CW'(DATA_BYTES - 1);
   localparam logic [CW-1:0] DUMMIES = CW'(DATA_BYTES + 1);
   localparam logic [CW-1:0] TX_ALL  = CW'(DATA_BYTES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     tx_q, tx_d;
   // Write byte count in WDATA, dummy byte count in the read states.
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     tx_left_q, tx_left_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              timeout_q, timeout_d;
   logic              drop_q, drop_d;

   logic byte_in;
   logic tx_hs;
   logic tmo_hit;

   assign s_axis_tready = 1'b1;
   assign reg_addr      = addr_q;
   assign reg_wdata     = wdata_q;
   assign reg_wr        = (state_q == WR_REQ);
   assign reg_rd        = (state_q == RD_REQ);
   assign m_axis_tvalid = (state_q == RD_SEND) && (tx_left_q != '0);
   assign m_axis_tdata  = tx_q[DW-1 -: 8];
   assign stat_timeout  = timeout_q;
   assign stat_drop     = drop_q;

   always_comb begin
      byte_in   = s_axis_tvalid;
      tx_hs     = m_axis_tvalid && m_axis_tready;
      // An arriving byte beats the timeout in the same cycle.
      tmo_hit   = (state_q != IDLE) && !byte_in && (tmo_q == TO_LAST);

      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tx_d      = tx_q;
      cnt_d     = cnt_q;
      tx_left_d = tx_left_q;
      timeout_d = 1'b0;
      drop_d    = 1'b0;
      tmo_d     = (state_q == IDLE || byte_in) ? '0 : tmo_q + TW'(1);

      if (tmo_hit) begin
         state_d   = IDLE;
         tx_left_d = '0;
         tmo_d     = '0;
         timeout_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (byte_in) begin
                  addr_d  = s_axis_tdata[ADDR_W-1:0];
                  cnt_d   = '0;
                  state_d = s_axis_tdata[CMD_RD_BIT] ? RD_REQ : WDATA;
               end
            end
            WDATA: begin
               if (byte_in) begin
                  wdata_d = (wdata_q << 8) | DW'(s_axis_tdata);
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q == LAST_WB) state_d = WR_REQ;
               end
            end
            WR_REQ: begin
               if (byte_in) drop_d = 1'b1;
               if (reg_ack) state_d = IDLE;
            end
            RD_REQ, RD_SEND: begin
               if (byte_in) begin
                  if (cnt_q == DUMMIES) drop_d = 1'b1;
                  else                  cnt_d  = cnt_q + CW'(1);
               end
               if (state_q == RD_REQ && reg_ack) begin
                  tx_d      = reg_rdata;
                  tx_left_d = TX_ALL;
                  state_d   = RD_SEND;
               end
               if (tx_hs) begin
                  tx_d      = tx_q << 8;
                  tx_left_d = tx_left_q - CW'(1);
               end
               // Frame ends once both TX drain and dummy count complete.
               if (state_q == RD_SEND && tx_left_d == '0 && cnt_d == DUMMIES)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         tx_q      <= '0;
         cnt_q     <= '0;
         tx_left_q <= '0;
         tmo_q     <= '0;
         timeout_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_q      <= tx_d;
         cnt_q     <= cnt_d;
         tx_left_q <= tx_left_d;
         tmo_q     <= tmo_d;
         timeout_q <= timeout_d;
         drop_q    <= drop_d;
      end
   end

endmodule
